// File: rtl/avalon_ir_rx_fifo.sv
// NEC infrared receiver with an Avalon-MM register window and a frame FIFO.
// Decodes 32-bit NEC frames and repeat codes; entries are {rep, addr[15:0], cmd[7:0]}.
module avalon_ir_rx_fifo #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       chipselect,
    input  logic [2:0] address,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       iIR,
    output logic       irq
);

    localparam int unsigned TickDiv = CLK_HZ / 100000;
    localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);

    localparam logic [AddrW-1:0] PtrOne    = 1;
    localparam logic [AddrW:0]   LevelOne  = 1;
    localparam logic [AddrW:0]   LevelFull = (AddrW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StLeadLow, StLeadHigh, StBitLow, StBitHigh, StStop
    } state_e;

    function automatic logic in_win(input logic [11:0] w, input logic [11:0] lo,
                                    input logic [11:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    logic        ir_s1_q, ir_s2_q, ir_prev_q;
    logic        rise, fall;
    logic [15:0] tick_cnt_q;
    logic        tick;
    logic [11:0] width_q;
    logic        width_sat;
    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q;
    logic [31:0] sr_q;
    logic        is_rep_q;

    logic err_evt, shift_en, shift_bit, start_bits, set_rep, frame_end, frame_bad;

    logic [24:0] pend_q;
    logic        pend_valid_q;
    logic        last_valid_q;
    logic [15:0] last_addr_q;
    logic [7:0]  last_cmd_q;

    logic [24:0]      mem_q [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   level_q;
    logic [4:0]       level_ext;
    logic [3:0]       level_nib;
    logic             empty, full, pop, flush, push_ok, drop;
    logic [24:0]      head;

    logic ie_q, rpt_q, ovf_q, err_q, irq_q;
    logic status_wr, ctrl_wr;
    logic unused_wdata;

    assign rise      = ir_s2_q & ~ir_prev_q;
    assign fall      = ~ir_s2_q & ir_prev_q;
    assign tick      = (tick_cnt_q == 16'(TickDiv - 1));
    assign width_sat = &width_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_s1_q    <= 1'b1;
            ir_s2_q    <= 1'b1;
            ir_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
            width_q    <= '0;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            is_rep_q   <= 1'b0;
        end else begin
            ir_s1_q    <= iIR;
            ir_s2_q    <= ir_s1_q;
            ir_prev_q  <= ir_s2_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 16'd1;
            if (rise || fall) begin
                width_q <= '0;
            end else if (tick && !width_sat) begin
                width_q <= width_q + 12'd1;
            end
            if (start_bits) begin
                bit_cnt_q <= '0;
                is_rep_q  <= 1'b0;
            end
            if (set_rep) begin
                is_rep_q <= 1'b1;
            end
            if (shift_en) begin
                sr_q      <= {shift_bit, sr_q[31:1]};
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Widths are in 10 us ticks, measured as the counter value at the edge.
    always_comb begin
        state_d    = state_q;
        err_evt    = 1'b0;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        start_bits = 1'b0;
        set_rep    = 1'b0;
        frame_end  = 1'b0;
        if (state_q != StIdle && width_sat) begin
            state_d = StIdle;
            err_evt = 1'b1;
        end else begin
            case (state_q)
                StIdle: if (fall) state_d = StLeadLow;
                StLeadLow: if (rise) begin
                    if (in_win(width_q, 12'd800, 12'd1000)) state_d = StLeadHigh;
                    else begin state_d = StIdle; err_evt = 1'b1; end
                end
                StLeadHigh: if (fall) begin
                    if (in_win(width_q, 12'd400, 12'd500)) begin
                        state_d    = StBitLow;
                        start_bits = 1'b1;
                    end else if (in_win(width_q, 12'd200, 12'd250)) begin
                        state_d = StStop;
                        set_rep = 1'b1;
                    end else begin
                        state_d = StIdle;
                        err_evt = 1'b1;
                    end
                end
                StBitLow: if (rise) begin
                    if (in_win(width_q, 12'd40, 12'd70)) state_d = StBitHigh;
                    else begin state_d = StIdle; err_evt = 1'b1; end
                end
                StBitHigh: if (fall) begin
                    if (in_win(width_q, 12'd40, 12'd70) || in_win(width_q, 12'd140, 12'd190)) begin
                        shift_en  = 1'b1;
                        shift_bit = in_win(width_q, 12'd140, 12'd190);
                        state_d   = (bit_cnt_q == 5'd31) ? StStop : StBitLow;
                    end else begin
                        state_d = StIdle;
                        err_evt = 1'b1;
                    end
                end
                StStop: if (rise) begin
                    state_d = StIdle;
                    if (in_win(width_q, 12'd40, 12'd70)) frame_end = 1'b1;
                    else err_evt = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign frame_bad = frame_end & ~is_rep_q & (sr_q[23:16] != ~sr_q[31:24]);

    assign status_wr = chipselect & write & (address == 3'd0);
    assign ctrl_wr   = chipselect & write & (address == 3'd1);
    assign flush     = ctrl_wr & writedata[2];
    assign empty     = (level_q == '0);
    assign full      = (level_q == LevelFull);
    assign pop       = chipselect & write & (address == 3'd5) & ~empty;
    assign push_ok   = pend_valid_q & ~flush & (~full | pop);
    assign drop      = pend_valid_q & ~flush & full & ~pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
            last_cmd_q   <= '0;
        end else begin
            pend_valid_q <= 1'b0;
            if (frame_end) begin
                if (is_rep_q) begin
                    if (rpt_q && last_valid_q) begin
                        pend_q       <= {1'b1, last_addr_q, last_cmd_q};
                        pend_valid_q <= 1'b1;
                    end
                end else if (!frame_bad) begin
                    pend_q       <= {1'b0, sr_q[15:0], sr_q[23:16]};
                    pend_valid_q <= 1'b1;
                    last_addr_q  <= sr_q[15:0];
                    last_cmd_q   <= sr_q[23:16];
                    last_valid_q <= 1'b1;
                end
            end
            if (flush) begin
                last_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push_ok && !pop)      level_q <= level_q + LevelOne;
            else if (pop && !push_ok) level_q <= level_q - LevelOne;
        end
    end

    // When full with a simultaneous pop, the write slot equals the slot being freed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ie_q  <= 1'b0;
            rpt_q <= 1'b0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ie_q  <= writedata[0];
                rpt_q <= writedata[1];
            end
            if (status_wr && writedata[1]) ovf_q <= 1'b0;
            if (drop) ovf_q <= 1'b1;
            if (status_wr && writedata[2]) err_q <= 1'b0;
            if (err_evt || frame_bad) err_q <= 1'b1;
            irq_q <= ie_q & ~empty;
        end
    end

    assign irq          = irq_q;
    assign head         = empty ? 25'd0 : mem_q[rd_ptr_q];
    assign level_ext    = 5'(level_q);
    assign level_nib    = (level_ext > 5'd15) ? 4'hF : level_ext[3:0];
    assign unused_wdata = ^writedata[7:3];

    always_comb begin
        readdata = 8'h00;
        if (chipselect && read) begin
            case (address)
                3'd0:    readdata = {level_nib, 1'b0, err_q, ovf_q, ~empty};
                3'd1:    readdata = {6'b0, rpt_q, ie_q};
                3'd2:    readdata = head[7:0];
                3'd3:    readdata = head[15:8];
                3'd4:    readdata = head[23:16];
                3'd5:    readdata = {7'b0, head[24]};
                default: readdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_ir_rx_fifo.sv
// Self-checking bench for avalon_ir_rx_fifo: drives NEC waveforms on iIR and
// compares register reads against a queue-based model of the decoded entries.
module tb_avalon_ir_rx_fifo;

    localparam int unsigned ClkHz = 100000;  // one tick per clk keeps frames short
    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       reset_n, chipselect, write, read, iIR, irq;
    logic [2:0] address;
    logic [7:0] writedata, readdata;

    int checks = 0;
    int fails  = 0;

    logic [24:0] exp_q[$];
    logic        m_ovf, m_err, m_lv, m_rpt;
    logic [15:0] m_addr;
    logic [7:0]  m_cmd;

    avalon_ir_rx_fifo #(.CLK_HZ(ClkHz), .FIFO_DEPTH(Depth)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .address   (address),
        .write     (write),
        .read      (read),
        .writedata (writedata),
        .readdata  (readdata),
        .iIR       (iIR),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic hold(input logic lvl, input int n);
        iIR = lvl;
        step(n);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0; read = 1'b0; address = 3'd0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        step(1);
        chipselect = 1'b0; write = 1'b0; address = 3'd0; writedata = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(1);
        exp_q.delete();
        m_ovf = 1'b0; m_err = 1'b0; m_lv = 1'b0; m_rpt = 1'b0;
        m_addr = '0; m_cmd = '0;
    endtask

    // NEC frame: 9 ms low, 4.5 ms high, 32 bits LSB first, 560 us stop burst.
    task automatic send_frame(input logic [15:0] a, input logic [7:0] c, input logic [7:0] inv,
                              input bit pop_at_push);
        logic [31:0] bits;
        bits = {inv, c, a};
        hold(1'b0, 820);
        hold(1'b1, 410);
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, 45);
            hold(1'b1, bits[i] ? 145 : 45);
        end
        hold(1'b0, 45);
        iIR = 1'b1;
        if (pop_at_push) begin
            // push lands two sync stages plus one clk after the rising edge
            step(3);
            address = 3'd5; chipselect = 1'b1; write = 1'b1;
            step(1);
            chipselect = 1'b0; write = 1'b0; address = 3'd0;
        end
        step(100);
    endtask

    task automatic send_repeat();
        hold(1'b0, 820);
        hold(1'b1, 210);
        hold(1'b0, 45);
        hold(1'b1, 100);
    endtask

    task automatic model_push(input logic [24:0] e);
        if (exp_q.size() == Depth) m_ovf = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic model_frame(input logic [15:0] a, input logic [7:0] c, input logic [7:0] inv);
        if (c != ~inv) begin
            m_err = 1'b1;
        end else begin
            m_lv = 1'b1; m_addr = a; m_cmd = c;
            model_push({1'b0, a, c});
        end
    endtask

    task automatic model_repeat();
        if (m_rpt && m_lv) model_push({1'b1, m_addr, m_cmd});
    endtask

    function automatic logic [7:0] exp_status();
        int n;
        n = exp_q.size();
        return {4'(n), 1'b0, m_err, m_ovf, n != 0};
    endfunction

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            checks++;
            if (d !== 8'h00) begin
                fails++;
                $display("FAIL reset_reg%0d: got %02h expected 00", a, d);
            end
        end
        checks++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_frame();
        logic [7:0] d;
        do_reset();
        wr(3'd1, 8'h01);
        send_frame(16'h00FF, 8'h45, 8'hBA, 1'b0);
        model_frame(16'h00FF, 8'h45, 8'hBA);
        rd(3'd0, d); checks++;
        if (d !== 8'h11 || d !== exp_status()) begin
            fails++; $display("FAIL frame_status: got %02h expected 11", d);
        end
        rd(3'd2, d); checks++;
        if (d !== 8'h45) begin fails++; $display("FAIL frame_cmd: got %02h expected 45", d); end
        rd(3'd3, d); checks++;
        if (d !== 8'hFF) begin fails++; $display("FAIL frame_addr_l: got %02h expected ff", d); end
        rd(3'd4, d); checks++;
        if (d !== 8'h00) begin fails++; $display("FAIL frame_addr_h: got %02h expected 00", d); end
        rd(3'd5, d); checks++;
        if (d !== 8'h00) begin fails++; $display("FAIL frame_head: got %02h expected 00", d); end
        checks++;
        if (irq !== 1'b1) begin fails++; $display("FAIL frame_irq: got %b expected 1", irq); end
        address = 3'd2; chipselect = 1'b1; read = 1'b0;
        #1 checks++;
        if (readdata !== 8'h00) begin
            fails++; $display("FAIL frame_noread: got %02h expected 00", readdata);
        end
        chipselect = 1'b0;
        wr(3'd5, 8'h00);
        void'(exp_q.pop_front());
        step(2);
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL pop_status: got %02h expected %02h", d, exp_status());
        end
        checks++;
        if (irq !== 1'b0) begin fails++; $display("FAIL pop_irq: got %b expected 0", irq); end
    endtask

    task automatic test_repeat();
        logic [7:0] d;
        logic [24:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            m_rpt = (pass == 0);
            wr(3'd1, {6'b0, m_rpt, 1'b0});
            send_frame(16'h00FF, 8'h45, 8'hBA, 1'b0);
            model_frame(16'h00FF, 8'h45, 8'hBA);
            send_repeat(); model_repeat();
            send_repeat(); model_repeat();
            rd(3'd0, d); checks++;
            if (d !== exp_status()) begin
                fails++;
                $display("FAIL repeat_status rpt=%0b: got %02h expected %02h", m_rpt, d, exp_status());
            end
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                rd(3'd2, d); checks++;
                if (d !== e[7:0]) begin
                    fails++; $display("FAIL repeat_cmd: got %02h expected %02h", d, e[7:0]);
                end
                rd(3'd5, d); checks++;
                if (d !== {7'b0, e[24]}) begin
                    fails++; $display("FAIL repeat_rep: got %02h expected %02h", d, {7'b0, e[24]});
                end
                wr(3'd5, 8'h00);
            end
        end
    endtask

    task automatic test_bad_inverse();
        logic [7:0] d;
        do_reset();
        send_frame(16'h00FF, 8'h45, 8'hBB, 1'b0);
        model_frame(16'h00FF, 8'h45, 8'hBB);
        rd(3'd0, d); checks++;
        if (d !== 8'h04 || d !== exp_status()) begin
            fails++; $display("FAIL badinv_status: got %02h expected 04", d);
        end
        wr(3'd0, 8'h04);
        m_err = 1'b0;
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL err_w1c: got %02h expected %02h", d, exp_status());
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  d, c;
        logic [15:0] a;
        logic [24:0] e;
        do_reset();
        for (int i = 0; i <= Depth; i++) begin
            a = 16'($urandom); c = 8'($urandom);
            send_frame(a, c, ~c, 1'b0);
            model_frame(a, c, ~c);
        end
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL ovf_status: got %02h expected %02h", d, exp_status());
        end
        e = exp_q[0];
        rd(3'd3, d); checks++;
        if (d !== e[15:8]) begin fails++; $display("FAIL ovf_head_l: got %02h expected %02h", d, e[15:8]); end
        rd(3'd4, d); checks++;
        if (d !== e[23:16]) begin fails++; $display("FAIL ovf_head_h: got %02h expected %02h", d, e[23:16]); end
        wr(3'd0, 8'h02);
        m_ovf = 1'b0;
        a = 16'($urandom); c = 8'($urandom);
        send_frame(a, c, ~c, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back({1'b0, a, c});
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL poppush_status: got %02h expected %02h", d, exp_status());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            rd(3'd2, d); checks++;
            if (d !== e[7:0]) begin fails++; $display("FAIL drain_cmd: got %02h expected %02h", d, e[7:0]); end
            rd(3'd3, d); checks++;
            if (d !== e[15:8]) begin fails++; $display("FAIL drain_addr_l: got %02h expected %02h", d, e[15:8]); end
            wr(3'd5, 8'h00);
        end
        wr(3'd5, 8'h00);
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL empty_pop_status: got %02h expected %02h", d, exp_status());
        end
        rd(3'd2, d); checks++;
        if (d !== 8'h00) begin fails++; $display("FAIL empty_head: got %02h expected 00", d); end
    endtask

    task automatic test_glitch_and_reset();
        logic [7:0]  d, c;
        logic [15:0] a;
        do_reset();
        hold(1'b0, 700);
        hold(1'b1, 300);
        hold(1'b0, 100);
        hold(1'b1, 300);
        m_err = 1'b1;
        rd(3'd0, d); checks++;
        if (d !== 8'h04 || d !== exp_status()) begin
            fails++; $display("FAIL glitch_status: got %02h expected 04", d);
        end
        wr(3'd1, 8'h03);
        hold(1'b0, 820);
        hold(1'b1, 410);
        for (int i = 0; i < 5; i++) begin
            hold(1'b0, 45);
            hold(1'b1, 145);
        end
        do_reset();
        step(200);
        for (int r = 0; r < 6; r++) begin
            rd(3'(r), d); checks++;
            if (d !== 8'h00) begin fails++; $display("FAIL midreset_reg%0d: got %02h expected 00", r, d); end
        end
        checks++;
        if (irq !== 1'b0) begin fails++; $display("FAIL midreset_irq: got %b expected 0", irq); end
        wr(3'd1, 8'h01);
        a = 16'($urandom); c = 8'($urandom);
        send_frame(a, c, ~c, 1'b0);
        model_frame(a, c, ~c);
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL after_reset_status: got %02h expected %02h", d, exp_status());
        end
        rd(3'd2, d); checks++;
        if (d !== c) begin fails++; $display("FAIL after_reset_cmd: got %02h expected %02h", d, c); end
        checks++;
        if (irq !== 1'b1) begin fails++; $display("FAIL after_reset_irq: got %b expected 1", irq); end
    endtask

    task automatic test_random();
        logic [7:0]  d, c, inv;
        logic [15:0] a;
        logic [24:0] e;
        do_reset();
        m_rpt = 1'($urandom_range(0, 1));
        wr(3'd1, {6'b0, m_rpt, 1'b0});
        a = 16'($urandom); c = 8'($urandom);
        inv = ($urandom_range(0, 2) == 0) ? (~c ^ 8'(1 << $urandom_range(0, 7))) : ~c;
        send_frame(a, c, inv, 1'b0);
        model_frame(a, c, inv);
        send_repeat(); model_repeat();
        send_repeat(); model_repeat();
        rd(3'd0, d); checks++;
        if (d !== exp_status()) begin
            fails++; $display("FAIL random_status: got %02h expected %02h", d, exp_status());
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            rd(3'd4, d); checks++;
            if (d !== e[23:16]) begin fails++; $display("FAIL random_addr_h: got %02h expected %02h", d, e[23:16]); end
            rd(3'd5, d); checks++;
            if (d !== {7'b0, e[24]}) begin fails++; $display("FAIL random_rep: got %02h expected %02h", d, {7'b0, e[24]}); end
            wr(3'd5, 8'h00);
        end
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 3'd0; writedata = 8'h00; iIR = 1'b1;
        step(2);
        test_reset();
        test_frame();
        test_repeat();
        test_bad_inverse();
        test_overflow();
        test_glitch_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
